// File: rtl/shift_sequencer_32.sv
// shift_sequencer_32: iterative 32-bit shifter.
// One request is captured at a time. The unit then applies the shift in five
// power-of-two stages (16, 8, 4, 2, 1), one stage per clock, reusing a single
// stage shift path. Right shifts are arithmetic; left shifts fill with zeros.
module shift_sequencer_32 #(
   parameter int WIDTH = 32,
   parameter int AMT_W = 5
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic             i_sh_dir,
   input  logic [AMT_W-1:0] i_sh_amt,
   input  logic [WIDTH-1:0] i_d_in,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_d_out
);

   localparam int K_W = $clog2(AMT_W);

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_SHIFT = 1'b1;

   logic [0:0]       r_state;
   logic [WIDTH-1:0] r_work;
   logic [AMT_W-1:0] r_amt;
   logic             r_dir;
   logic [K_W-1:0]   r_k;
   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] r_d_out;

   logic [AMT_W-1:0] w_step;
   logic [WIDTH-1:0] w_sra;
   logic [WIDTH-1:0] w_sll;
   logic [WIDTH-1:0] w_stage;

   // Single shared stage path: shift the working value by 2^k when amount bit k is set.
   // w_sra refills the vacated top bits from the sign of the current working value.
   always_comb begin
      w_step  = AMT_W'(1) << r_k;
      w_sra   = $unsigned($signed(r_work) >>> w_step);
      w_sll   = r_work << w_step;
      w_stage = r_work;
      if (r_amt[r_k]) begin
         w_stage = r_dir ? w_sra : w_sll;
      end
   end

   // Request capture, MSB-first stage sequencing, and result/DONE registration.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
         r_work  <= '0;
         r_amt   <= '0;
         r_dir   <= 1'b0;
         r_k     <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_d_out <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_work  <= i_d_in;
                  r_amt   <= i_sh_amt;
                  r_dir   <= i_sh_dir;
                  r_k     <= K_W'(AMT_W - 1);
                  r_busy  <= 1'b1;
                  r_state <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               r_work <= w_stage;
               if (r_k == '0) begin
                  // Last stage: publish the result; BUSY drops in the DONE cycle.
                  r_d_out <= w_stage;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_k <= r_k - 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign o_busy  = r_busy;
   assign o_done  = r_done;
   assign o_d_out = r_d_out;

endmodule

// File: tb/tb_shift_sequencer_32.sv
// tb_shift_sequencer_32: directed and randomized checks of shift_sequencer_32
// against a bit-at-a-time shift reference model.
module tb_shift_sequencer_32;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        sh_dir;
   logic [4:0]  sh_amt;
   logic [31:0] d_in;
   logic        busy;
   logic        done;
   logic [31:0] d_out;

   int checks = 0;
   int errors = 0;

   shift_sequencer_32 #(.WIDTH(32), .AMT_W(5)) dut (
      .i_clk    (clk),
      .i_rst_n  (rst_n),
      .i_start  (start),
      .i_sh_dir (sh_dir),
      .i_sh_amt (sh_amt),
      .i_d_in   (d_in),
      .o_busy   (busy),
      .o_done   (done),
      .o_d_out  (d_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: apply the shift one bit position at a time.
   function automatic logic [31:0] ref_shift(input logic dir, input logic [4:0] amt,
                                             input logic [31:0] d);
      logic [31:0] r;
      r = d;
      for (int i = 0; i < int'(amt); i++) begin
         if (dir) r = {r[31], r[31:1]};
         else     r = {r[30:0], 1'b0};
      end
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issue one request (START asserted on the next negedge) and follow it to DONE.
   task automatic run_req(input string tag, input logic dir, input logic [4:0] amt,
                          input logic [31:0] d);
      logic [31:0] exp;
      exp = ref_shift(dir, amt, d);
      @(negedge clk);
      start = 1'b1; sh_dir = dir; sh_amt = amt; d_in = d;
      @(posedge clk); #1;
      start = 1'b0; d_in = $urandom; sh_amt = 5'($urandom); sh_dir = 1'($urandom);
      chk({tag, " busy@E0"}, 32'(busy), 32'd1);
      chk({tag, " done@E0"}, 32'(done), 32'd0);
      for (int e = 1; e <= 4; e++) begin
         @(posedge clk); #1;
         chk({tag, " busy@Ek"}, 32'(busy), 32'd1);
         chk({tag, " done@Ek"}, 32'(done), 32'd0);
      end
      @(posedge clk); #1;
      chk({tag, " done@E5"}, 32'(done), 32'd1);
      chk({tag, " busy@E5"}, 32'(busy), 32'd0);
      chk({tag, " dout"}, d_out, exp);
      $display("req %s dir=%0d amt=%0d d=%h -> dout=%h exp=%h", tag, dir, amt, d, d_out, exp);
   endtask

   // Idle cycles with no request: nothing may be busy or done.
   task automatic idle_cycles(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         chk({tag, " idle busy"}, 32'(busy), 32'd0);
         chk({tag, " idle done"}, 32'(done), 32'd0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] held;
      rst_n = 1'b0; start = 1'b0; sh_dir = 1'b0; sh_amt = '0; d_in = '0;
      #1;
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      chk("reset dout", d_out, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Idle after reset: outputs stay at zero.
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         chk("idle busy", 32'(busy), 32'd0);
         chk("idle done", 32'(done), 32'd0);
         chk("idle dout", d_out, 32'd0);
      end

      // Directed cases.
      run_req("sll8", 1'b0, 5'd8, 32'h0000_00FF);
      chk("sll8 value", d_out, 32'h0000_FF00);
      idle_cycles("after sll8", 1);
      chk("dout hold", d_out, 32'h0000_FF00);
      run_req("sra31", 1'b1, 5'd31, 32'h8000_0000);
      chk("sra31 value", d_out, 32'hFFFF_FFFF);
      run_req("sra4", 1'b1, 5'd4, 32'h7FFF_FFFF);
      chk("sra4 value", d_out, 32'h07FF_FFFF);
      run_req("amt0", 1'b0, 5'd0, 32'h1234_5678);
      chk("amt0 value", d_out, 32'h1234_5678);
      idle_cycles("after amt0", 2);

      // Ignored START while busy, then back-to-back request in the DONE cycle.
      @(negedge clk);
      start = 1'b1; sh_dir = 1'b0; sh_amt = 5'd31; d_in = 32'h0000_0001;
      @(posedge clk); #1;                       // E0
      start = 1'b0;
      @(posedge clk); #1;                       // E1
      @(posedge clk); #1;                       // E2
      start = 1'b1; sh_dir = 1'b1; sh_amt = 5'd0; d_in = 32'hFFFF_FFFF;
      @(posedge clk); #1;                       // E3
      start = 1'b0;
      chk("ign busy@E3", 32'(busy), 32'd1);
      @(posedge clk); #1;                       // E4
      chk("ign done@E4", 32'(done), 32'd0);
      @(posedge clk); #1;                       // E5
      chk("ign done@E5", 32'(done), 32'd1);
      chk("ign dout", d_out, 32'h8000_0000);
      $display("req ignored-start dout=%h exp=80000000", d_out);
      run_req("b2b", 1'b1, 5'd3, 32'hF000_00F0);
      chk("b2b value", d_out, 32'hFE00_001E);
      held = d_out;

      // Reset mid-operation: everything clears at once, request discarded.
      @(negedge clk);
      start = 1'b1; sh_dir = 1'b0; sh_amt = 5'd1; d_in = 32'h0000_0003;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      #2 rst_n = 1'b0;
      #1;
      chk("midrst busy", 32'(busy), 32'd0);
      chk("midrst done", 32'(done), 32'd0);
      chk("midrst dout", d_out, 32'd0);
      chk("midrst dout changed", 32'(d_out !== held), 32'd1);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         chk("post-rst no done", 32'(done), 32'd0);
         chk("post-rst busy", 32'(busy), 32'd0);
         chk("post-rst dout", d_out, 32'd0);
      end
      $display("req midrst discarded dout=%h", d_out);
      run_req("after-rst", 1'b0, 5'd4, 32'h0000_000F);
      chk("after-rst value", d_out, 32'h0000_00F0);

      // Randomized requests with random idle gaps (0 = back-to-back).
      for (int n = 0; n < 40; n++) begin
         logic        rdir;
         logic [4:0]  ramt;
         logic [31:0] rd;
         int          gap;
         rdir = 1'($urandom);
         ramt = 5'($urandom);
         rd   = $urandom;
         gap  = $urandom_range(0, 2);
         run_req("rand", rdir, ramt, rd);
         if (gap > 0) idle_cycles("rand gap", gap);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/shift_sequencer_32.md
# shift_sequencer_32

Multi-cycle 32-bit shift unit that captures one shift request and resolves it one power-of-two stage per clock (16, 8, 4, 2, 1), reusing a single per-stage shift path. It sits directly upstream of the result consumer and drives the same stage semantics as the fixed-amount shifter stages: arithmetic (sign-fill) right shift, zero-fill left shift. It trades latency for area against the fully combinational five-stage chain.

## Interface
- WIDTH, 32, data width; only 32 is supported.
- AMT_W, 5, shift-amount width, always log2(WIDTH); sets the number of iteration cycles.

- CLK  input  1  single clock, rising edge.
- RST_N  input  1  reset; asynchronous and active-low.
- START  input  1  request strobe; sampled only while BUSY=0.
- SH_DIR  input  1  1 = arithmetic shift right, 0 = logical shift left; captured with START.
- SH_AMT  input  AMT_W  shift amount, 0..31; captured with START.
- D_IN  input  WIDTH  operand; captured with START.
- BUSY  output  1  high while a request is in progress.
- DONE  output  1  one-cycle pulse; D_OUT is valid and new in that cycle.
- D_OUT  output  WIDTH  registered result; holds its value until the next completion.

## Operation
- State machine has two states, IDLE and SHIFT.
- IDLE: if START=1, capture D_IN into the working register, SH_AMT into the amount register, and SH_DIR into the direction register.
  - Set the stage index k = AMT_W-1 and go to SHIFT.
  - If START=0, stay in IDLE.
- SHIFT, one stage per cycle:
  - If amount bit k is 1, shift the working register by 2^k.
    - Right shift: result[31-2^k:0] = w[31:2^k]; the top 2^k bits are filled with w[31], the sign of the current working value.
    - Left shift: result[31:2^k] = w[31-2^k:0]; the low 2^k bits are filled with 0.
  - If amount bit k is 0, the working register is unchanged.
  - When k=0, load the stage result into D_OUT, pulse DONE, and go to IDLE. Otherwise decrement k.
- Stages are applied MSB first, so the total shift equals SH_AMT exactly. Amount bits never carry across stages.
- SH_AMT=0 still takes the full iteration and produces D_OUT = D_IN.
- While BUSY=1, START, SH_DIR, SH_AMT and D_IN are ignored. There is no queuing; a dropped START is not remembered.
- Reset (RST_N=0) at any time forces the following immediately, and the in-flight request is discarded with no DONE:
  - state to IDLE;
  - BUSY=0, DONE=0;
  - D_OUT=0x0000_0000;
  - working, amount, direction and index registers to 0.

## Timing
- Edge E0 samples START=1 in IDLE. BUSY is 1 from E0.
- Edges E1..E5 execute stages k = 4, 3, 2, 1, 0.
- At E5:
  - D_OUT is updated;
  - DONE=1 for the cycle following E5;
  - BUSY returns to 0 in that same cycle.
- Fixed latency: START-sampling edge to DONE is AMT_W = 5 clocks, regardless of SH_AMT or SH_DIR.
- Back-to-back requests: START=1 in the DONE cycle is accepted at the next edge. Sustained throughput is one result per 6 cycles.
- DONE is never high for two consecutive cycles.
- BUSY and DONE are never high in the same cycle.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- Reset, then hold START=0 for 10 cycles -> D_OUT=0x0000_0000, BUSY=0, DONE=0 throughout.
- D_IN=0x0000_00FF, SH_DIR=0, SH_AMT=8, START for one cycle -> BUSY high for 5 cycles; DONE pulses exactly 5 clocks after the sampling edge; D_OUT=0x0000_FF00.
- Right shifts:
  - D_IN=0x8000_0000, SH_DIR=1, SH_AMT=31 -> D_OUT=0xFFFF_FFFF.
  - D_IN=0x7FFF_FFFF, SH_DIR=1, SH_AMT=4 -> D_OUT=0x07FF_FFFF.
- D_IN=0x1234_5678, SH_AMT=0 -> D_OUT=0x1234_5678 after the full 5-cycle latency.
- Ignored START and back-to-back:
  - Start a left shift of 0x0000_0001 by 31.
  - Re-assert START with D_IN=0xFFFF_FFFF at cycle 2 -> ignored; D_OUT=0x8000_0000.
  - START in the DONE cycle is accepted, and its result arrives 5 clocks later.
- Reset mid-operation:
  - Assert RST_N=0 asynchronously 2 cycles into a request -> D_OUT=0, BUSY=0 immediately, and no DONE ever appears for that request.
  - After release, a new request completes correctly.
